// File: rtl/rf_writeback_queue.sv
// In-order writeback queue that merges the WB stage and mul/div unit onto the single
// regfile write port, with snoop forwarding of queued data to the two read addresses.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in0_valid,
    output logic                         in0_ready,
    input  logic [AW-1:0]                in0_addr,
    input  logic [DW-1:0]                in0_data,
    input  logic                         in1_valid,
    output logic                         in1_ready,
    input  logic [AW-1:0]                in1_addr,
    input  logic [DW-1:0]                in1_data,
    output logic                         rf_wen,
    output logic [AW-1:0]                rf_addr,
    output logic [DW-1:0]                rf_wd,
    input  logic [AW-1:0]                ra1,
    input  logic [AW-1:0]                ra2,
    output logic                         hit1,
    output logic                         hit2,
    output logic [DW-1:0]                fwd1,
    output logic [DW-1:0]                fwd2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    tail1;
    logic             store0;
    logic             store1;
    logic             pop;

    // Readiness looks only at the registered count, so it never depends on this cycle's pop.
    always_comb begin
        in0_ready = (count <= CW'(DEPTH-1));
        in1_ready = (count <= CW'(DEPTH-2)) || (!in0_valid && (count <= CW'(DEPTH-1)));
        store0    = in0_valid && in0_ready && (in0_addr != '0);
        store1    = in1_valid && in1_ready && (in1_addr != '0);
        pop       = (count != '0);
        tail1     = tail + PW'(store0);
        rf_wen    = pop;
        rf_addr   = pop ? q_addr[head] : '0;
        rf_wd     = pop ? q_data[head] : '0;
    end

    // Walk from oldest to newest so the last match seen is the newest queued value.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
        logic          hit;
        logic [DW-1:0] d;
        logic [PW-1:0] idx;
        hit = 1'b0;
        d   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (q_valid[idx] && (q_addr[idx] == ra) && (ra != '0)) begin
                hit = 1'b1;
                d   = q_data[idx];
            end
        end
        return {hit, d};
    endfunction

    always_comb begin
        {hit1, fwd1} = lookup(ra1);
        {hit2, fwd2} = lookup(ra2);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (store0) begin
                q_addr[tail]  <= in0_addr;
                q_data[tail]  <= in0_data;
                q_valid[tail] <= 1'b1;
            end
            if (store1) begin
                q_addr[tail1]  <= in1_addr;
                q_data[tail1]  <= in1_data;
                q_valid[tail1] <= 1'b1;
            end
            tail  <= tail + PW'(store0) + PW'(store1);
            count <= count + CW'(store0) + CW'(store1) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!resetn) count <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!resetn) !(rf_wen && (rf_addr == '0)));

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: regfile writes are checked against an expected
// queue; readiness, count and forwarding are checked against hand-derived values.
module tb_rf_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in0_valid, in0_ready, in1_valid, in1_ready;
    logic [AW-1:0] in0_addr, in1_addr, rf_addr, ra1, ra2;
    logic [DW-1:0] in0_data, in1_data, rf_wd, fwd1, fwd2;
    logic          rf_wen, hit1, hit2;
    logic [$clog2(DEPTH+1)-1:0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;

    always #5 clk = ~clk;

    rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
        .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in0_valid = v;
        in0_addr  = a;
        in0_data  = d;
    endtask

    task automatic drive1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in1_valid = v;
        in1_addr  = a;
        in1_data  = d;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && count != 0; k++) cycle();
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every regfile write must be the next expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rf_extra_write", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("rf_write", 64'({rf_addr, rf_wd}), 64'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int m;
        logic v0, e0r, e1r;
        int st;
        resetn = 1'b0;
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        ra1 = '0;
        ra2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rdy0", 64'(in0_ready), 64'd1);
        check("rst_rdy1", 64'(in1_ready), 64'd1);
        check("rst_addr", 64'(rf_addr), 64'd0);
        check("rst_wd", 64'(rf_wd), 64'd0);
        check("rst_hit", 64'({hit1, hit2}), 64'd0);
        resetn = 1'b1;
        cycle();

        // Reset with three entries queued: only the first write escapes.
        drive0(1'b1, 5'd1, 32'h101);
        drive1(1'b1, 5'd2, 32'h102);
        exp_q.push_back({5'd1, 32'h101});
        cycle();
        check("mid_cnt2", 64'(count), 64'd2);
        drive0(1'b1, 5'd3, 32'h103);
        drive1(1'b1, 5'd4, 32'h104);
        cycle();
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        check("mid_cnt3", 64'(count), 64'd3);
        resetn = 1'b0;
        #1;
        check("mid_rst_wen", 64'(rf_wen), 64'd0);
        check("mid_rst_cnt", 64'(count), 64'd0);
        check("mid_rst_rdy", 64'({in0_ready, in1_ready}), 64'd3);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) cycle();
        check("mid_no_write", 64'(exp_q.size()), 64'd0);
        check("mid_cnt_after", 64'(count), 64'd0);

        // Single write.
        drive0(1'b1, 5'd5, 32'hAAAA0005);
        exp_q.push_back({5'd5, 32'hAAAA0005});
        #1;
        check("single_rdy0", 64'(in0_ready), 64'd1);
        cycle();
        drive0(1'b0, '0, '0);
        check("single_cnt1", 64'(count), 64'd1);
        check("single_wen1", 64'(rf_wen), 64'd1);
        cycle();
        check("single_cnt0", 64'(count), 64'd0);
        check("single_wen0", 64'(rf_wen), 64'd0);

        // Dual write to the same register: port 1 is newer.
        drive0(1'b1, 5'd3, 32'h11);
        drive1(1'b1, 5'd3, 32'h22);
        exp_q.push_back({5'd3, 32'h11});
        exp_q.push_back({5'd3, 32'h22});
        cycle();
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        ra1 = 5'd3;
        ra2 = 5'd7;
        #1;
        check("dual_cnt2", 64'(count), 64'd2);
        check("dual_hit1", 64'(hit1), 64'd1);
        check("dual_fwd1", 64'(fwd1), 64'h22);
        check("dual_miss", 64'({hit2, fwd2}), 64'd0);
        cycle();
        check("dual_cnt1", 64'(count), 64'd1);
        check("dual_fwd1_b", 64'({hit1, fwd1}), 64'h1_0000_0022);
        cycle();
        check("dual_empty_fwd", 64'({hit1, fwd1}), 64'd0);
        ra1 = '0;

        // Zero register: handshake completes but nothing is stored.
        drive0(1'b1, 5'd0, 32'hDEAD);
        ra2 = 5'd0;
        #1;
        check("zero_rdy0", 64'(in0_ready), 64'd1);
        cycle();
        drive0(1'b0, '0, '0);
        check("zero_cnt", 64'(count), 64'd0);
        check("zero_wen", 64'(rf_wen), 64'd0);
        check("zero_fwd2", 64'({hit2, fwd2}), 64'd0);

        // Backpressure: both ports held valid, in0 dropped for one cycle.
        m = 0;
        for (int i = 0; i < 10; i++) begin
            v0 = (i != 6);
            drive0(v0, 5'(i + 1), 32'h4000_0000 | 32'(i));
            drive1(1'b1, 5'(i + 17), 32'h5000_0000 | 32'(i));
            #1;
            e0r = (m <= DEPTH - 1);
            e1r = (m <= DEPTH - 2) || (!v0 && m <= DEPTH - 1);
            check("bp_rdy0", 64'(in0_ready), 64'(e0r));
            check("bp_rdy1", 64'(in1_ready), 64'(e1r));
            st = 0;
            if (v0 && e0r) begin
                exp_q.push_back({5'(i + 1), 32'h4000_0000 | 32'(i)});
                st++;
            end
            if (e1r) begin
                exp_q.push_back({5'(i + 17), 32'h5000_0000 | 32'(i)});
                st++;
            end
            cycle();
            m = m + st - ((m != 0) ? 1 : 0);
            check("bp_count", 64'(count), 64'(m));
            check("bp_le_depth", 64'(count <= DEPTH), 64'd1);
        end
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        drain("bp_drain");

        // Ten sequential writes wrap both pointers more than once.
        for (int i = 1; i <= 10; i++) begin
            drive0(1'b1, 5'(i), 32'hC0DE_0000 + 32'(i));
            exp_q.push_back({5'(i), 32'hC0DE_0000 + 32'(i)});
            cycle();
            check("wrap_cnt", 64'(count), 64'd1);
        end
        drive0(1'b0, '0, '0);
        drain("wrap_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
